// File: rtl/ss_ddr_arbiter.sv
// Round-robin arbiter sharing one 64-bit toggle-handshake DDR port between two clients.
// Client 0 is the savestate engine; client 1 is relocated into its own window via C1_ADDR_XOR.
module ss_ddr_arbiter #(
    parameter logic [18:0] C1_ADDR_XOR = 19'h0
) (
    input  logic        clk,
    input  logic        reset_n,

    input  logic        c0_req,
    output logic        c0_ack,
    input  logic [18:0] c0_addr,
    input  logic        c0_we,
    input  logic [7:0]  c0_be,
    input  logic [63:0] c0_do,
    output logic [63:0] c0_di,

    input  logic        c1_req,
    output logic        c1_ack,
    input  logic [18:0] c1_addr,
    input  logic        c1_we,
    input  logic [7:0]  c1_be,
    input  logic [63:0] c1_do,
    output logic [63:0] c1_di,

    output logic        ddr_req,
    input  logic        ddr_ack,
    output logic [18:0] ddr_addr,
    output logic        ddr_we,
    output logic [7:0]  ddr_be,
    output logic [63:0] ddr_do,
    input  logic [63:0] ddr_di,

    output logic        busy,
    output logic        owner
);

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t state;
    state_t state_next;
    logic   pend0;
    logic   pend1;
    logic   grant_en;
    logic   grant_sel;
    logic   done;

    assign pend0 = (c0_req != c0_ack);
    assign pend1 = (c1_req != c1_ack);
    assign busy  = (state == WAIT);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // On a tie the client that did not own the last grant wins, so grants alternate.
    always_comb begin
        state_next = state;
        grant_en   = 1'b0;
        grant_sel  = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (pend0 && pend1) begin
                    grant_sel = ~owner;
                end else begin
                    grant_sel = pend1;
                end
                if (pend0 || pend1) begin
                    grant_en   = 1'b1;
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (ddr_ack == ddr_req) begin
                    done       = 1'b1;
                    state_next = IDLE;
                end
            end
        endcase
    end

    // Request fields stay registered until the next grant; the DDR port samples them on the req toggle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ddr_req  <= 1'b0;
            ddr_addr <= 19'h0;
            ddr_we   <= 1'b0;
            ddr_be   <= 8'hFF;
            ddr_do   <= 64'h0;
            owner    <= 1'b1;
            c0_ack   <= 1'b0;
            c1_ack   <= 1'b0;
            c0_di    <= 64'h0;
            c1_di    <= 64'h0;
        end else begin
            if (grant_en) begin
                owner   <= grant_sel;
                ddr_req <= ~ddr_req;
                if (grant_sel) begin
                    ddr_addr <= c1_addr ^ C1_ADDR_XOR;
                    ddr_we   <= c1_we;
                    ddr_be   <= c1_be;
                    ddr_do   <= c1_do;
                end else begin
                    ddr_addr <= c0_addr;
                    ddr_we   <= c0_we;
                    ddr_be   <= c0_be;
                    ddr_do   <= c0_do;
                end
            end
            if (done) begin
                if (owner) begin
                    c1_ack <= ~c1_ack;
                    if (!ddr_we) begin
                        c1_di <= ddr_di;
                    end
                end else begin
                    c0_ack <= ~c0_ack;
                    if (!ddr_we) begin
                        c0_di <= ddr_di;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ss_ddr_arbiter.sv
// Directed bench for ss_ddr_arbiter: a 3-cycle toggle-handshake DDR model plus hand-computed expectations.
module tb_ss_ddr_arbiter;

    localparam logic [18:0] XOR1 = 19'h40000;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        c0_req, c0_ack, c0_we, c1_req, c1_ack, c1_we;
    logic [18:0] c0_addr, c1_addr, ddr_addr;
    logic [7:0]  c0_be, c1_be, ddr_be;
    logic [63:0] c0_do, c0_di, c1_do, c1_di, ddr_do, ddr_di;
    logic        ddr_req, ddr_ack, ddr_we, busy, owner;

    int n_compared = 0;
    int n_mismatched = 0;

    always #5 clk = ~clk;

    ss_ddr_arbiter #(.C1_ADDR_XOR(XOR1)) dut (
        .clk(clk), .reset_n(reset_n),
        .c0_req(c0_req), .c0_ack(c0_ack), .c0_addr(c0_addr), .c0_we(c0_we),
        .c0_be(c0_be), .c0_do(c0_do), .c0_di(c0_di),
        .c1_req(c1_req), .c1_ack(c1_ack), .c1_addr(c1_addr), .c1_we(c1_we),
        .c1_be(c1_be), .c1_do(c1_do), .c1_di(c1_di),
        .ddr_req(ddr_req), .ddr_ack(ddr_ack), .ddr_addr(ddr_addr), .ddr_we(ddr_we),
        .ddr_be(ddr_be), .ddr_do(ddr_do), .ddr_di(ddr_di),
        .busy(busy), .owner(owner)
    );

    // Read data pattern: address 1 returns 64'h5345_4E53.
    function automatic logic [63:0] rdata(input logic [18:0] a);
        return 64'h5345_4E53 ^ {45'h0, a ^ 19'h1};
    endfunction

    // DDR model: acknowledges three cycles after a req toggle, shares reset_n with the arbiter.
    logic [1:0] ddr_cnt;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ddr_ack <= 1'b0;
            ddr_di  <= 64'h0;
            ddr_cnt <= 2'd0;
        end else if (ddr_req != ddr_ack) begin
            if (ddr_cnt == 2'd2) begin
                ddr_ack <= ddr_req;
                ddr_di  <= rdata(ddr_addr);
                ddr_cnt <= 2'd0;
            end else begin
                ddr_cnt <= ddr_cnt + 2'd1;
            end
        end
    end

    // Grant monitor: logs owner per ddr_req toggle, flags two grants without an idle cycle between.
    logic grant_q[$];
    logic prev_req = 1'b0;
    int   grants_since_idle = 0;
    int   busy_viol = 0;
    initial begin
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                prev_req = 1'b0;
                grants_since_idle = 0;
            end else begin
                if (!busy) grants_since_idle = 0;
                if (ddr_req != prev_req) begin
                    prev_req = ddr_req;
                    grant_q.push_back(owner);
                    grants_since_idle++;
                    if (grants_since_idle > 1) busy_viol++;
                end
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        n_compared++;
        if (observed !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic client, input logic [18:0] addr, input logic we,
                                 input logic [7:0] be, input logic [63:0] data);
        if (!client) begin
            c0_addr = addr; c0_we = we; c0_be = be; c0_do = data;
            c0_req = ~c0_req;
        end else begin
            c1_addr = addr; c1_we = we; c1_be = be; c1_do = data;
            c1_req = ~c1_req;
        end
    endtask

    task automatic waitAck(input logic client, input int limit, input string tag);
        logic ok = 1'b0;
        for (int n = 0; n < limit; n++) begin
            @(negedge clk);
            if (client ? (c1_ack == c1_req) : (c0_ack == c0_req)) begin
                ok = 1'b1;
                break;
            end
        end
        checkOutput({tag, "_ack_done"}, {63'h0, ok}, 64'h1);
    endtask

    task automatic waitDdrAck(input int limit, input string tag);
        logic ok = 1'b0;
        for (int n = 0; n < limit; n++) begin
            @(negedge clk);
            if (ddr_ack == ddr_req) begin
                ok = 1'b1;
                break;
            end
        end
        checkOutput({tag, "_ddr_done"}, {63'h0, ok}, 64'h1);
    endtask

    task automatic doReset();
        reset_n = 1'b0;
        c0_req = 1'b0;
        c1_req = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int  n0;
        int  n1;
        int  hold_err;
        logic ok;

        c0_req = 0; c0_addr = 0; c0_we = 0; c0_be = 8'hFF; c0_do = 0;
        c1_req = 0; c1_addr = 0; c1_we = 0; c1_be = 8'hFF; c1_do = 0;
        repeat (3) @(negedge clk);

        checkOutput("rst_ddr_req", ddr_req, 0);
        checkOutput("rst_c0_ack", c0_ack, 0);
        checkOutput("rst_c1_ack", c1_ack, 0);
        checkOutput("rst_owner", owner, 1);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_ddr_be", ddr_be, 8'hFF);
        checkOutput("rst_ddr_addr", ddr_addr, 0);
        checkOutput("rst_c0_di", c0_di, 0);
        checkOutput("rst_c1_di", c1_di, 0);
        reset_n = 1'b1;
        @(negedge clk);

        // Single client 0 read
        applyStimulus(0, 19'h00001, 0, 8'hFF, 64'h0);
        @(negedge clk);
        checkOutput("t1_ddr_req", ddr_req, 1);
        checkOutput("t1_ddr_addr", ddr_addr, 19'h00001);
        checkOutput("t1_ddr_we", ddr_we, 0);
        checkOutput("t1_owner", owner, 0);
        checkOutput("t1_busy", busy, 1);
        waitDdrAck(10, "t1");
        checkOutput("t1_ack_early", c0_ack, 0);
        @(negedge clk);
        checkOutput("t1_c0_ack", c0_ack, 1);
        checkOutput("t1_c0_di", c0_di, 64'h5345_4E53);
        checkOutput("t1_c1_ack", c1_ack, 0);
        checkOutput("t1_c1_di", c1_di, 0);
        checkOutput("t1_busy_idle", busy, 0);

        // Client 1 write, relocated address
        applyStimulus(1, 19'h00010, 1, 8'hF0, 64'hA5);
        @(negedge clk);
        checkOutput("t2_ddr_req", ddr_req, 0);
        checkOutput("t2_ddr_addr", ddr_addr, 19'h40010);
        checkOutput("t2_ddr_we", ddr_we, 1);
        checkOutput("t2_ddr_be", ddr_be, 8'hF0);
        checkOutput("t2_ddr_do", ddr_do, 64'hA5);
        checkOutput("t2_owner", owner, 1);
        waitAck(1, 20, "t2");
        checkOutput("t2_c1_ack", c1_ack, 1);
        checkOutput("t2_c1_di", c1_di, 0);
        checkOutput("t2_c0_ack", c0_ack, 1);

        // Tie after reset: client 0 first, client 1 two cycles after completion
        doReset();
        applyStimulus(0, 19'h00002, 0, 8'hFF, 64'h0);
        applyStimulus(1, 19'h00003, 0, 8'hFF, 64'h0);
        @(negedge clk);
        checkOutput("tie_owner0", owner, 0);
        checkOutput("tie_addr0", ddr_addr, 19'h00002);
        checkOutput("tie_req0", ddr_req, 1);
        waitDdrAck(10, "tie");
        @(negedge clk);
        checkOutput("tie_c0_ack", c0_ack, 1);
        checkOutput("tie_no_regrant", ddr_req, 1);
        checkOutput("tie_idle", busy, 0);
        @(negedge clk);
        checkOutput("tie_req1", ddr_req, 0);
        checkOutput("tie_owner1", owner, 1);
        checkOutput("tie_addr1", ddr_addr, 19'h40003);
        waitAck(1, 20, "tie");

        // Fairness: both clients re-toggle on every ack, 8 transactions
        grant_q.delete();
        busy_viol = 0;
        applyStimulus(0, 19'h00123, 0, 8'hFF, 64'h0);
        applyStimulus(1, 19'h00456, 0, 8'hFF, 64'h0);
        n0 = 1;
        n1 = 1;
        ok = 1'b0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            @(negedge clk);
            if (c0_ack == c0_req && n0 < 4) begin c0_req = ~c0_req; n0++; end
            if (c1_ack == c1_req && n1 < 4) begin c1_req = ~c1_req; n1++; end
            if (n0 == 4 && n1 == 4 && c0_ack == c0_req && c1_ack == c1_req) begin
                ok = 1'b1;
                break;
            end
        end
        checkOutput("fair_done", {63'h0, ok}, 64'h1);
        @(negedge clk);
        checkOutput("fair_count", grant_q.size(), 8);
        for (int i = 0; i < 8; i++) begin
            checkOutput($sformatf("fair_grant%0d", i),
                        (i < grant_q.size()) ? {63'h0, grant_q[i]} : 64'hx, i % 2);
        end
        checkOutput("fair_c0_di", c0_di, 64'h5345_4F71);
        checkOutput("fair_c1_di", c1_di, 64'h5341_4A04);
        checkOutput("fair_busy_gap", busy_viol, 0);

        // Late arrival: client 1 toggles while client 0 is in WAIT
        applyStimulus(0, 19'h00007, 0, 8'hFF, 64'h0);
        @(negedge clk);
        checkOutput("late_owner0", owner, 0);
        checkOutput("late_addr0", ddr_addr, 19'h00007);
        @(negedge clk);
        applyStimulus(1, 19'h00020, 0, 8'hFF, 64'h0);
        hold_err = 0;
        ok = 1'b0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge clk);
            if (ddr_addr != 19'h00007) hold_err++;
            if (c0_ack == c0_req) begin
                ok = 1'b1;
                break;
            end
        end
        checkOutput("late_c0_done", {63'h0, ok}, 64'h1);
        checkOutput("late_addr_hold", hold_err, 0);
        @(negedge clk);
        checkOutput("late_owner1", owner, 1);
        checkOutput("late_addr1", ddr_addr, 19'h40020);
        waitAck(1, 20, "late");
        checkOutput("late_c1_di", c1_di, 64'h5341_4E72);

        // Reset asserted during WAIT
        applyStimulus(0, 19'h00003, 0, 8'hFF, 64'h0);
        @(negedge clk);
        checkOutput("mid_busy_pre", busy, 1);
        checkOutput("mid_req_pre", ddr_req, 1);
        #2 reset_n = 1'b0;
        #1;
        checkOutput("mid_ddr_req", ddr_req, 0);
        checkOutput("mid_c0_ack", c0_ack, 0);
        checkOutput("mid_c1_ack", c1_ack, 0);
        checkOutput("mid_owner", owner, 1);
        checkOutput("mid_busy", busy, 0);
        c0_req = 1'b0;
        c1_req = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        applyStimulus(0, 19'h00001, 0, 8'hFF, 64'h0);
        @(negedge clk);
        checkOutput("post_ddr_req", ddr_req, 1);
        waitAck(0, 20, "post");
        checkOutput("post_c0_ack", c0_ack, 1);
        checkOutput("post_c0_di", c0_di, 64'h5345_4E53);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
